// File: rtl/delay_tap.sv
// delay_tap: a DEPTH-stage {valid, data} shift chain that is read at a programmable tap.
// A tap change waits until no accepted word is in flight, so words are never duplicated or dropped.
module delay_tap #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 32,
  parameter int RESET_POS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic [7:0]       out_pos,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [7:0]       cur_pos,
  output logic             pos_pending,
  output logic             busy,
  output logic             pos_err
);
  localparam logic [7:0] DEPTH_W     = 8'(DEPTH);
  localparam logic [7:0] RESET_POS_W = 8'(RESET_POS);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];
  logic [DEPTH-1:0] tap_hit;
  logic [7:0]       cur_pos_q, cur_pos_d;
  logic [7:0]       occ_q, occ_d;
  logic             pos_err_q, pos_err_d;
  logic [7:0]       pos_clamped;
  logic             clamp_hit;
  logic             apply_pos;

  // A word that moves past the tap loses its valid bit, so it cannot be shown again
  // if the tap is later moved further down the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      data_q[0]  <= data_in;
      valid_q[0] <= valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1] && (cur_pos_q > 8'(i));
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      assign tap_hit[gi] = (cur_pos_q == 8'(gi + 1));
    end
  endgenerate

  always_comb begin
    data_out  = '0;
    valid_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_hit[i]) begin
        data_out  = data_q[i];
        valid_out = valid_q[i];
      end
    end
  end

  always_comb begin
    pos_clamped = out_pos;
    clamp_hit   = 1'b0;
    if (out_pos == 8'd0) begin
      pos_clamped = 8'd1;
      clamp_hit   = 1'b1;
    end else if (out_pos > DEPTH_W) begin
      pos_clamped = DEPTH_W;
      clamp_hit   = 1'b1;
    end
  end

  assign pos_pending = (out_pos != cur_pos_q);
  assign apply_pos   = pos_pending && (occ_q == 8'd0) && !valid_in;

  always_comb begin
    cur_pos_d = cur_pos_q;
    pos_err_d = pos_err_q;
    if (apply_pos) begin
      cur_pos_d = pos_clamped;
      pos_err_d = pos_err_q | clamp_hit;
    end
    occ_d = occ_q + {7'd0, valid_in} - {7'd0, valid_out};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_pos_q <= RESET_POS_W;
      occ_q     <= 8'd0;
      pos_err_q <= 1'b0;
    end else begin
      cur_pos_q <= cur_pos_d;
      occ_q     <= occ_d;
      pos_err_q <= pos_err_d;
    end
  end

  assign cur_pos = cur_pos_q;
  assign busy    = (occ_q != 8'd0);
  assign pos_err = pos_err_q;
endmodule
